// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller.
// Each digit owns a slot of CLK_DIV cycles; the first BLANK cycles of a slot
// keep all anodes off so the previous digit's pattern cannot ghost.
// Display data is latched once per frame so a frame never mixes old and new data.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned BLANK   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_DIG = 8;

  typedef struct packed {
    logic [31:0] value;
    logic [7:0]  dig_en;
    logic [7:0]  dp_in;
  } shadow_t;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  shadow_t          shadow;

  logic       tick_c;
  logic       capture_c;
  logic       blank_c;
  logic [3:0] nib_c;
  logic [7:0] an_c;
  logic [6:0] seg_c;
  logic       dp_c;

  // Active-low hex to {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick_c    = (cnt == CNT_W'(CLK_DIV - 1));
  assign capture_c = tick_c && (idx == IDX_W'(N_DIG - 1));

  // Ghost-guard window at the head of each slot (absent when BLANK is zero)
  if (BLANK == 0) begin : g_no_blank
    assign blank_c = 1'b0;
  end else begin : g_blank
    assign blank_c = (cnt < CNT_W'(BLANK));
  end

  // Next display drive from the current slot position and latched data
  always_comb begin
    an_c  = 8'hFF;
    seg_c = 7'h7F;
    dp_c  = 1'b1;
    nib_c = shadow.value[{idx, 2'b00} +: 4];
    if (!blank_c && shadow.dig_en[idx]) begin
      an_c  = ~(8'b1 << idx);
      seg_c = decode(nib_c);
      dp_c  = ~shadow.dp_in[idx];
    end
  end

  // Prescaler, slot index and once-per-frame data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
    end else begin
      cnt <= tick_c ? '0 : cnt + CNT_W'(1);
      if (tick_c) begin
        idx <= idx + IDX_W'(1);
      end
      if (capture_c) begin
        shadow <= {value, dig_en, dp_in};
      end
    end
  end

  // Registered display outputs and frame-start pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      an    <= 8'hFF;
      seg   <= 7'h7F;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_c;
      seg   <= seg_c;
      dp    <= dp_c;
      frame <= capture_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios then random traffic, all checked
// cycle by cycle against a time-based reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned BLANK   = 1;
  localparam int unsigned FRAME   = 8 * CLK_DIV;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] value;
  logic [7:0]  dig_en;
  logic [7:0]  dp_in;

  logic [7:0] an,  an0;
  logic [6:0] seg, seg0;
  logic       dp,  dp0;
  logic       frame, frame0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK(BLANK)) u_dut (
    .clk(clk), .rst(rst), .value(value), .dig_en(dig_en), .dp_in(dp_in),
    .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK(0)) u_dut0 (
    .clk(clk), .rst(rst), .value(value), .dig_en(dig_en), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0), .frame(frame0)
  );

  // Reference: t counts clean cycles since reset; slot and phase follow from t.
  int unsigned t_m;
  logic [47:0] sh_m;
  logic [7:0]  e_an,  e_an0;
  logic [6:0]  e_seg, e_seg0;
  logic        e_dp,  e_dp0;
  logic        e_frame;

  function automatic logic [15:0] exp_out(input int unsigned t, input int unsigned blank,
                                          input logic [47:0] sh);
    int unsigned slot;
    int unsigned ph;
    logic [31:0] v;
    logic [7:0]  en;
    logic [7:0]  dpi;
    logic [7:0]  a;
    slot = (t / CLK_DIV) % 8;
    ph   = t % CLK_DIV;
    v    = sh[47:16];
    en   = sh[15:8];
    dpi  = sh[7:0];
    if (ph < blank || !en[slot]) return {8'hFF, 7'h7F, 1'b1};
    a = 8'h01 << slot;
    return {~a, SEG_TBL[v[4*slot +: 4]], ~dpi[slot]};
  endfunction

  // Model advance on each rising edge
  always @(posedge clk) begin
    if (rst) begin
      t_m     <= 0;
      sh_m    <= '0;
      {e_an, e_seg, e_dp}    <= {8'hFF, 7'h7F, 1'b1};
      {e_an0, e_seg0, e_dp0} <= {8'hFF, 7'h7F, 1'b1};
      e_frame <= 1'b0;
    end else begin
      {e_an, e_seg, e_dp}    <= exp_out(t_m, BLANK, sh_m);
      {e_an0, e_seg0, e_dp0} <= exp_out(t_m, 0, sh_m);
      e_frame <= ((t_m % FRAME) == FRAME - 1);
      if ((t_m % FRAME) == FRAME - 1) sh_m <= {value, dig_en, dp_in};
      t_m <= t_m + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("an",     32'(an),     32'(e_an));
    chk("seg",    32'(seg),    32'(e_seg));
    chk("dp",     32'(dp),     32'(e_dp));
    chk("frame",  32'(frame),  32'(e_frame));
    chk("an_b0",  32'(an0),    32'(e_an0));
    chk("seg_b0", 32'(seg0),   32'(e_seg0));
    chk("dp_b0",  32'(dp0),    32'(e_dp0));
    chk("frame_b0", 32'(frame0), 32'(e_frame));
    chk("an_onecold", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    value  = 32'h7654_3210;
    dig_en = 8'hFF;
    dp_in  = 8'h00;
    rst    = 1'b1;
    step();
    step();
    chk("rst_an",    32'(an),    32'hFF);
    chk("rst_seg",   32'(seg),   32'h7F);
    chk("rst_dp",    32'(dp),    32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    rst = 1'b0;

    // Frames 0..4 of the directed scenario, i = cycles since reset release
    for (int i = 1; i <= 4 * FRAME + 2; i++) begin
      step();
      if (i <= FRAME) begin
        chk("f0_dark",  32'(an),    32'hFF);
        chk("f0_frame", 32'(frame), 32'(i == FRAME));
      end
      if (i == 33) chk("f1_s0_blank", 32'(an), 32'hFF);
      if (i >= 34 && i <= 36) begin
        chk("f1_s0_an",  32'(an),  32'hFE);
        chk("f1_s0_seg", 32'(seg), 32'h40);
      end
      if (i == 38) begin
        chk("f1_s1_an",  32'(an),  32'hFD);
        chk("f1_s1_seg", 32'(seg), 32'h79);
      end
      if (i >= 33 && i <= 64) chk("b0_one_lit", 32'($countones(~an0)), 32'd1);
      if (i == 40) begin
        dig_en = 8'h05;
        dp_in  = 8'h04;
      end
      if (i >= 65 && i <= 96) begin
        chk("f2_an_set", 32'(an == 8'hFF || an == 8'hFE || an == 8'hFB), 32'd1);
        chk("f2_dp",     32'(dp), 32'(an != 8'hFB));
      end
      if (i == 80) begin
        dig_en = 8'hFF;
        dp_in  = 8'h00;
      end
      if (i == 110) value = 32'hFFFF_FFFF;
      if (i >= 110 && i <= 128) chk("f3_old_digits", 32'(seg != 7'h0E), 32'd1);
      if (i == 130) begin
        chk("f4_new_an",  32'(an),  32'hFE);
        chk("f4_new_seg", 32'(seg), 32'h0E);
      end
    end

    // Reset while idx=5, cnt=2 (state position 22 within the frame)
    value = 32'h0123_4567;
    for (int k = 0; k < int'(FRAME) && (t_m % FRAME) != 22; k++) step();
    rst = 1'b1;
    step();
    chk("midrst_an",    32'(an),    32'hFF);
    chk("midrst_seg",   32'(seg),   32'h7F);
    chk("midrst_frame", 32'(frame), 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= int'(FRAME) + 4; i++) begin
      step();
      if (i <= int'(FRAME)) begin
        chk("post_rst_dark",  32'(an),    32'hFF);
        chk("post_rst_frame", 32'(frame), 32'(i == int'(FRAME)));
      end
    end

    // Random traffic with occasional one-cycle resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) value  = $urandom;
      if ($urandom_range(0, 19) == 0) dig_en = 8'($urandom);
      if ($urandom_range(0, 19) == 0) dp_in  = 8'($urandom);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be:
- CLK_DIV, 100000, clk cycles per digit slot (>= 2).
- BLANK, 2, cycles at the start of each slot with all anodes off (ghost guard); 0 <= BLANK < CLK_DIV.
REQ-002 The module SHALL have one clock and a synchronous, active-high reset; the ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- value  in  32  eight hex nibbles; digit i = value[4i+3:4i].
- dig_en  in  8  per-digit enable; 0 blanks that digit.
- dp_in  in  8  per-digit decimal point; 1 lights it.
- an  out  8  anode select, active-low, one-cold (digit i -> an[i]=0).
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- frame  out  1  one-cycle pulse when a new frame starts (slot 7 -> slot 0).

Function
REQ-003 A prescaler cnt SHALL count 0..CLK_DIV-1 and wrap to 0; tick = (cnt == CLK_DIV-1).
REQ-004 The slot index idx (3 bits) SHALL increment on tick and wrap from 7 to 0; otherwise it holds.
REQ-005 A shadow register SHALL capture {value, dig_en, dp_in} on the cycle where tick=1 and idx=7, so a frame never mixes old and new data.
REQ-006 frame SHALL be registered and equal 1 for exactly the one cycle after the shadow capture; otherwise 0.
REQ-007 an, seg and dp SHALL be registered; their values in cycle n+1 are derived from cnt, idx and the shadow in cycle n.
REQ-008 When cnt < BLANK, or shadow dig_en[idx]=0, the outputs SHALL be an=8'hFF, seg=7'h7F, dp=1.
REQ-009 Otherwise the outputs SHALL be:
- an = ~(8'b1 << idx).
- seg = decode(shadow nibble idx).
- dp = ~shadow dp_in[idx].
REQ-010 The decode table (active-low, hex) SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-011 At most one an bit SHALL be 0 in any cycle.
REQ-012 Changes to value, dig_en or dp_in mid-frame SHALL have no visible effect until the next capture.
REQ-013 With dig_en=0 in the shadow, an SHALL stay 8'hFF permanently while cnt, idx and frame keep running.
REQ-014 BLANK=0 SHALL give no blank cycles; each enabled digit is then lit for all CLK_DIV cycles of its slot.

Reset
REQ-015 While rst=1 at a clock edge, the next state SHALL be:
- cnt=0, idx=0, shadow=0.
- an=8'hFF, seg=7'h7F, dp=1, frame=0.
REQ-016 Reset asserted mid-slot or mid-frame SHALL abort the current slot; after rst falls, slot 0 restarts from cnt=0.
REQ-017 After reset the shadow is all-zero (all digits disabled) until the first capture at the end of frame 0, so the display stays dark for the whole first frame.

Verification (CLK_DIV=4, BLANK=1 unless noted)
REQ-018 Release reset with value=32'h76543210, dig_en=8'hFF, dp_in=0:
- Frame 0: an=FF throughout; frame pulses once after 32 cycles.
- Frame 1 slot 0: an=FF for 1 cycle, then an=FE with seg=40 for 3 cycles.
- Frame 1 slot 1: an=FD with seg=79.
REQ-019 Set dig_en=8'h05, dp_in=8'h04 before the capture:
- Next frame: only an=FE and an=FB appear.
- Slot 2 has dp=0; every other slot has dp=1.
REQ-020 Change value to 32'hFFFFFFFF during slot 3: the remaining slots of the current frame still show the old digits; seg=0E appears only from the next frame.
REQ-021 Assert rst for 1 cycle while idx=5 and cnt=2: next cycle an=FF, seg=7F, frame=0; scanning restarts at idx=0, cnt=0.
REQ-022 BLANK=0, all digits enabled: every cycle has exactly one an bit low, each digit for 4 consecutive cycles; never an=FF after frame 1 begins.
